// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: parser states, frame type codes and default sync marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_TYPE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } parser_state_e;

  localparam logic [7:0] TYPE_CMD          = 8'h00;
  localparam logic [7:0] TYPE_DATA         = 8'h01;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO of 9-bit entries ({dc, data}); pushes while full are dropped.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [8:0]             wdata,
  output logic [8:0]             rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign count  = count_q;
  // An empty FIFO presents zero rather than a stale entry.
  assign rdata  = empty ? 9'h000 : mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts for sync/type/len/payload[/csum] frames in the UART byte stream and queues payload for the OLED driver.
// Define PARSER_CSUM_EN to expect a trailing XOR checksum byte; otherwise frames end on the last payload byte.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         TIMEOUT_CYC = 17360
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_dval,
  output logic [7:0] out_data,
  output logic       out_dc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int             IW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0]  IDLE_LIMIT = IW'(TIMEOUT_CYC - 1);

  parser_state_e state_q, state_d;
  logic          dc_q, dc_d;
  logic [7:0]    rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PARSER_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic                        fifoPush;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [8:0]                  fifoRdata;
  logic [$clog2(FIFO_DEPTH):0] unusedFifoCount;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (out_ready),
    .wdata ({dc_q, rx_data}),
    .rdata (fifoRdata),
    .empty (fifoEmpty),
    .full  (fifoFull),
    .count (unusedFifoCount)
  );

  assign {out_dc, out_data} = fifoRdata;
  assign out_valid  = !fifoEmpty;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_HUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HUNT;
      dc_q    <= 1'b0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARSER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PARSER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Byte-driven transitions; the idle timeout is the only move that happens without rx_dval.
  always_comb begin
    state_d  = state_q;
    dc_d     = dc_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    idle_d   = idle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fifoPush = 1'b0;
`ifdef PARSER_CSUM_EN
    csum_d   = csum_q;
`endif
    if (rx_dval) begin
      idle_d = '0;
      case (state_q)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) state_d = S_TYPE;
        end
        S_TYPE: begin
          if (rx_data == TYPE_CMD || rx_data == TYPE_DATA) begin
            dc_d    = (rx_data == TYPE_DATA);
            ovf_d   = 1'b0;
            state_d = S_LEN;
`ifdef PARSER_CSUM_EN
            csum_d  = rx_data;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
        S_LEN: begin
          rem_d = rx_data;
`ifdef PARSER_CSUM_EN
          csum_d = csum_q ^ rx_data;
          state_d = (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
`else
          if (rx_data == 8'd0) begin
            done_d  = 1'b1;
            state_d = S_HUNT;
          end else begin
            state_d = S_PAYLOAD;
          end
`endif
        end
        S_PAYLOAD: begin
          // Fullness is judged at cycle start, so a same-cycle pop never rescues the byte.
          fifoPush = 1'b1;
          if (fifoFull) ovf_d = 1'b1;
          rem_d = rem_q - 1'b1;
`ifdef PARSER_CSUM_EN
          csum_d = csum_q ^ rx_data;
          if (rem_q == 8'd1) state_d = S_CSUM;
`else
          if (rem_q == 8'd1) begin
            state_d = S_HUNT;
            if (ovf_q || fifoFull) err_d = 1'b1;
            else                   done_d = 1'b1;
          end
`endif
        end
`ifdef PARSER_CSUM_EN
        S_CSUM: begin
          if (rx_data == csum_q && !ovf_q) done_d = 1'b1;
          else                             err_d  = 1'b1;
          state_d = S_HUNT;
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end else if (state_q != S_HUNT) begin
      if (idle_q == IDLE_LIMIT) begin
        err_d   = 1'b1;
        state_d = S_HUNT;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames from the test plan plus randomized frames
// checked against a frame-level reference model; follows PARSER_CSUM_EN the same way the design does.
module tb_uart_frame_parser;

  localparam logic [7:0] SYNC        = 8'hA5;
  localparam int         FIFO_DEPTH  = 16;
  localparam int         TIMEOUT_CYC = 17360;
`ifdef PARSER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [7:0] byteQ_t [$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dval = 1'b0;
  logic [7:0] out_data;
  logic       out_dc;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int         passCount = 0;
  int         failCount = 0;
  int         checkCount = 0;
  int         readyMode = 0;
  logic [8:0] expQ [$];

  uart_frame_parser #(
    .SYNC_BYTE   (SYNC),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_dval    (rx_dval),
    .out_data   (out_data),
    .out_dc     (out_dc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Consumer side: 0 = stalled, 1 = always ready, otherwise random.
  always @(negedge clk) begin
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Every accepted head must match the oldest payload byte the model expects.
  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      checkOutput("modelHasEntry", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkOutput("fifoHead", {out_dc, out_data}, expQ.pop_front());
    end
  end

  // Drive one byte for one cycle, then check the pulses for that byte and for the idle gap after it.
  task automatic applyStimulus(input logic [7:0] b, input bit expDone, input bit expErr, input int gap);
    rx_data = b;
    rx_dval = 1'b1;
    @(negedge clk);
    rx_dval = 1'b0;
    checkOutput("frameDone", frame_done, expDone);
    checkOutput("frameErr", frame_err, expErr);
    repeat (gap) begin
      @(negedge clk);
      checkOutput("doneIdle", frame_done, 1'b0);
      checkOutput("errIdle", frame_err, 1'b0);
    end
  endtask

  // Frame-level model: builds the byte sequence and decides the outcome from the frame contents.
  // room = how many payload bytes the FIFO can still take (no draining during the frame assumed when small).
  task automatic sendFrame(input logic [7:0] typ, input byteQ_t pl, input bit badCsum,
                           input int room, input int maxGap);
    byteQ_t     bytes;
    logic [7:0] csum;
    bit         validType;
    bit         ovf;
    bit         good;
    int         n;
    validType = (typ == 8'h00 || typ == 8'h01);
    bytes = {};
    bytes.push_back(SYNC);
    bytes.push_back(typ);
    if (validType) begin
      bytes.push_back(8'(pl.size()));
      foreach (pl[i]) bytes.push_back(pl[i]);
      csum = typ ^ 8'(pl.size());
      foreach (pl[i]) csum = csum ^ pl[i];
      if (CSUM_EN) bytes.push_back(badCsum ? (csum ^ 8'hFD) : csum);
    end
    ovf  = validType && (pl.size() > room);
    good = validType && !ovf && !(CSUM_EN && badCsum);
    n = bytes.size();
    for (int i = 0; i < n; i++) begin
      if (validType && i >= 3 && i < 3 + pl.size() && (i - 3) < room)
        expQ.push_back({typ[0], bytes[i]});
      applyStimulus(bytes[i], (i == n - 1) && good, (i == n - 1) && !good,
                    $urandom_range(0, maxGap));
      if (i == 0 && n > 1) checkOutput("busyAfterSync", busy, 1'b1);
    end
    checkOutput("busyAfterFrame", busy, 1'b0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((out_valid || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainValidLow", out_valid, 1'b0);
    checkOutput("drainModelEmpty", expQ.size(), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    byteQ_t pl;
    int     earlyErr;
    logic [7:0] b;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetValid", out_valid, 1'b0);
    checkOutput("resetDone", frame_done, 1'b0);
    checkOutput("resetErr", frame_err, 1'b0);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetData", {out_dc, out_data}, 9'h000);

    $display("[TB] basic data frame");
    readyMode = 1;
    @(negedge clk);
    pl = {8'h11, 8'h22, 8'h33};
    sendFrame(8'h01, pl, 1'b0, 1000, 2);
    waitDrain();

    $display("[TB] bad checksum frame");
    sendFrame(8'h01, pl, 1'b1, 1000, 1);
    waitDrain();

    $display("[TB] noise then command frame");
    applyStimulus(8'h00, 1'b0, 1'b0, 0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1);
    applyStimulus(8'h5A, 1'b0, 1'b0, 0);
    checkOutput("busyAfterNoise", busy, 1'b0);
    pl = {8'hAE};
    sendFrame(8'h00, pl, 1'b0, 1000, 0);
    waitDrain();

    $display("[TB] bad type then good frame");
    pl = {};
    sendFrame(8'h07, pl, 1'b0, 1000, 0);
    pl = {8'h5C, 8'hA5};
    sendFrame(8'h01, pl, 1'b0, 1000, 0);
    waitDrain();

    $display("[TB] inter-byte timeout");
    readyMode = 0;
    repeat (2) @(negedge clk);
    applyStimulus(SYNC, 1'b0, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 1'b0, 0);
    applyStimulus(8'h02, 1'b0, 1'b0, 0);
    expQ.push_back({1'b1, 8'h10});
    applyStimulus(8'h10, 1'b0, 1'b0, 0);
    earlyErr = 0;
    repeat (TIMEOUT_CYC - 1) begin
      @(negedge clk);
      if (frame_err || frame_done) earlyErr++;
    end
    checkOutput("timeoutNotEarly", earlyErr, 0);
    checkOutput("busyBeforeTimeout", busy, 1'b1);
    @(negedge clk);
    checkOutput("timeoutErr", frame_err, 1'b1);
    checkOutput("timeoutDone", frame_done, 1'b0);
    checkOutput("timeoutBusy", busy, 1'b0);
    @(negedge clk);
    checkOutput("timeoutErrWidth", frame_err, 1'b0);
    checkOutput("timeoutKeepsHead", {out_valid, out_dc, out_data}, {1'b1, 1'b1, 8'h10});
    readyMode = 1;
    waitDrain();

    $display("[TB] overflow with stalled consumer");
    readyMode = 0;
    repeat (2) @(negedge clk);
    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'(8'h40 + i));
    sendFrame(8'h01, pl, 1'b0, FIFO_DEPTH, 0);
    checkOutput("ovfHead", {out_valid, out_dc, out_data}, {1'b1, 1'b1, 8'h40});
    readyMode = 1;
    waitDrain();

    $display("[TB] reset mid-frame");
    readyMode = 0;
    repeat (2) @(negedge clk);
    applyStimulus(SYNC, 1'b0, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 1'b0, 0);
    applyStimulus(8'h03, 1'b0, 1'b0, 0);
    expQ.push_back({1'b1, 8'h11});
    applyStimulus(8'h11, 1'b0, 1'b0, 0);
    checkOutput("preResetValid", out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    expQ.delete();
    checkOutput("midResetValid", out_valid, 1'b0);
    checkOutput("midResetBusy", busy, 1'b0);
    checkOutput("midResetPulse", {frame_done, frame_err}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postResetPulse", {frame_done, frame_err}, 2'b00);
    readyMode = 1;
    pl = {8'h01, 8'h02};
    sendFrame(8'h00, pl, 1'b0, 1000, 0);
    waitDrain();

    $display("[TB] randomized frames");
    readyMode = 2;
    for (int f = 0; f < 40; f++) begin
      int    r;
      int    len;
      logic [7:0] typ;
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        applyStimulus(b, 1'b0, 1'b0, $urandom_range(0, 2));
      end
      r = $urandom_range(0, 9);
      typ = (r == 0) ? 8'($urandom_range(2, 255)) : 8'(r % 2);
      len = $urandom_range(0, 8);
      pl = {};
      repeat (len) pl.push_back(8'($urandom));
      sendFrame(typ, pl, ($urandom_range(0, 3) == 0), 1000, 3);
      waitDrain();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART receiver's byte stream. It hunts for framed packets (sync, type, length, payload, checksum) in the stream of received bytes. Payload bytes go into an internal FIFO, tagged with an OLED data/command (D/C) bit, and the FIFO drains to the OLED SPI driver over a valid/ready handshake. Each frame ends with a one-cycle done or error pulse.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- FIFO_DEPTH, 16, payload FIFO entries (power of 2, ≥4)
- TIMEOUT_CYC, 17360, idle clocks between bytes before an in-progress frame is abandoned (4 byte times at 434 clk/bit)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART receiver
- rx_dval  in  1  one-cycle strobe, rx_data valid; no backpressure possible
- out_data  out  8  FIFO head byte
- out_dc  out  1  FIFO head D/C tag (1 = display data, 0 = command)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- frame_done  out  1  one-cycle pulse, frame accepted
- frame_err  out  1  one-cycle pulse, frame rejected or abandoned
- busy  out  1  parser not in HUNT

## Operation
- Reset values: out_valid=0, frame_done=0, frame_err=0, busy=0. out_data/out_dc=0. FIFO empty, state HUNT, all counters 0.
- States: HUNT, TYPE, LEN, PAYLOAD, CSUM. All transitions occur only on rx_dval cycles, except the timeout.
- HUNT: rx_data==SYNC_BYTE → TYPE. Any other byte is ignored.
- TYPE: 8'h00 → dc=0 (command). 8'h01 → dc=1 (data). Either moves to LEN with csum=rx_data and ovf=0. Any other value → frame_err, HUNT.
- LEN: len=rx_data, csum^=rx_data. len==0 → CSUM; otherwise → PAYLOAD with remaining=len.
- PAYLOAD: each byte is pushed as {dc, rx_data} and folded in with csum^=rx_data. remaining decrements; when it reaches 0 → CSUM.
- CSUM: frame_done pulses if rx_data==csum and ovf==0; otherwise frame_err pulses. Then → HUNT.
- Payload already in the FIFO is never recalled on error. frame_err is advisory to the downstream control logic.
- Overflow: a push when count==FIFO_DEPTH (evaluated at cycle start, regardless of a same-cycle pop) drops the byte and sets ovf. Parsing continues to the frame end.
- Timeout: an idle counter clears on every rx_dval and increments when busy. When it reaches TIMEOUT_CYC: frame_err, → HUNT.
- SYNC_BYTE inside TYPE/LEN/PAYLOAD/CSUM is treated as an ordinary byte; there is no resync.
- FIFO: show-ahead. out_data/out_dc always reflect the head entry. A pop occurs when out_valid && out_ready. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: FIFO flushed, state HUNT, no pulse emitted.

## Timing
- rx_dval at cycle t → state, csum and FIFO write at the edge ending t. out_valid is high in t+1 if the FIFO was empty.
- frame_done/frame_err assert in t+1 for the closing byte at t. Width is exactly 1 cycle.
- Timeout pulse: frame_err asserts TIMEOUT_CYC+1 cycles after the last rx_dval.
- Throughput: one pop per cycle. Push rate is bounded by UART, 1 per ≥10 bit times.
- busy is registered and follows the state (high in t+1 after the sync byte at t).

## Configuration
- PARSER_CSUM_EN defined: CSUM state present; a checksum byte is expected after the payload.
- Not defined: CSUM state and csum register removed. The frame ends on the last payload byte (or at LEN when len==0). frame_done pulses if ovf==0, else frame_err. Frame length is one byte shorter.

## Structure
- Package uart_frame_pkg: state enum, TYPE_CMD=8'h00, TYPE_DATA=8'h01, default SYNC_BYTE.
- Sub-module byte_fifo: synchronous 9-bit-wide show-ahead FIFO, parameter DEPTH. Ports: push, pop, wdata, rdata, empty, full, count.

## Test plan
- A5 01 03 11 22 33 02, out_ready=1 → out {1,11},{1,22},{1,33} in order; frame_done one cycle after the 02 byte.
- Same frame with checksum FF → three bytes still output; frame_err pulses, no frame_done.
- Noise 00 FF 5A, then A5 00 01 AE AF → noise ignored; out {0,AE}; frame_done.
- A5 07 → frame_err after 07, busy drops; a following valid frame is parsed normally.
- A5 01 02 10, then silence → frame_err at TIMEOUT_CYC+1 cycles after 10; FIFO keeps {1,10}.
- out_ready=0, FIFO_DEPTH=16, A5 01 14 + 20 bytes + csum → 16 entries held (first 16 bytes); frame_err; draining yields exactly those 16.
